// File: rtl/trn_dac3482_axil_regs.sv
// trn_dac3482_axil_regs: AXI4-Lite slave with four 32-bit control registers
// and a one-cycle write pulse per register for the DAC3482 control logic.
module trn_dac3482_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] REG_RESET_VALUE = '0
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
  output logic [3:0]                      reg_wr_pulse_o
);
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;
  logic                          live, aw_held, w_held, bvalid, rvalid;
  logic [1:0]                    aw_sel, sel;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data, data, rdata;
  logic [SW-1:0]                 w_strb, strb;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
  logic [3:0]                    pulse;
  logic                          aw_hs, w_hs, ar_hs, commit;
  logic                          unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  // live keeps every READY low while reset is held, without an input-to-output path
  assign S_AXI_AWREADY = live && !aw_held && !bvalid;
  assign S_AXI_WREADY  = live && !w_held && !bvalid;
  assign S_AXI_ARREADY = live && !rvalid;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RRESP   = 2'b00;
  assign reg0_o = regs[0];
  assign reg1_o = regs[1];
  assign reg2_o = regs[2];
  assign reg3_o = regs[3];
  assign reg_wr_pulse_o = pulse;
  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit = (aw_held || aw_hs) && (w_held || w_hs);
  assign sel    = aw_held ? aw_sel : S_AXI_AWADDR[3:2];
  assign data   = w_held ? w_data : S_AXI_WDATA;
  assign strb   = w_held ? w_strb : S_AXI_WSTRB;
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      live    <= 1'b0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_sel  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      pulse   <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= REG_RESET_VALUE;
    end else begin
      live  <= 1'b1;
      pulse <= commit ? 4'b0001 << sel : 4'b0000;
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        for (int b = 0; b < SW; b++)
          if (strb[b]) regs[sel][8*b +: 8] <= data[8*b +: 8];
      end else begin
        if (aw_hs) begin
          aw_held <= 1'b1;
          aw_sel  <= S_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
          w_held <= 1'b1;
          w_data <= S_AXI_WDATA;
          w_strb <= S_AXI_WSTRB;
        end
        if (bvalid && S_AXI_BREADY) bvalid <= 1'b0;
      end
      // reads sample the array before this edge's write lands
      if (ar_hs) begin
        rvalid <= 1'b1;
        rdata  <= regs[S_AXI_ARADDR[3:2]];
      end else if (rvalid && S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_trn_dac3482_axil_regs.sv
// tb_trn_dac3482_axil_regs: directed write/read, ordering, strobe,
// backpressure, collision and reset checks with hand-computed expectations.
module tb_trn_dac3482_axil_regs;
  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, reg0, reg1, reg2, reg3;
  logic [3:0]  pulse;
  int          tests = 0, fails = 0;
  always #5 clk = ~clk;
  trn_dac3482_axil_regs dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg0_o(reg0), .reg1_o(reg1), .reg2_o(reg2), .reg3_o(reg3), .reg_wr_pulse_o(pulse)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input logic [3:0] p);
    check("wr_ready", {awready, wready}, 2'b11);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_bvalid", bvalid, 1'b1);
    check("wr_bresp", bresp, 2'b00);
    check("wr_pulse", pulse, p);
  endtask
  task automatic b_done();
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("b_done", {bvalid, pulse}, 5'b0);
  endtask
  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    check("rd_ready", arready, 1'b1);
    araddr = a; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("rd_rvalid", rvalid, 1'b1);
    check("rd_rresp", rresp, 2'b00);
    check("rd_rdata", rdata, e);
  endtask
  task automatic r_done();
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("r_done", rvalid, 1'b0);
  endtask
  initial begin
    for (int i = 0; i < 20; i++) begin
      tick();
      check("rst_hs", {awready, wready, arready, bvalid, rvalid}, 5'b0);
      check("rst_regs", reg0 | reg1 | reg2 | reg3, 32'h0);
    end
    aresetn = 1'b1;
    tick();
    check("rel_ready", {awready, wready, arready}, 3'b111);
    // sequential write then readback
    for (int i = 0; i < 4; i++) begin
      wr(4'(4 * i), 32'(i + 1), 4'hF, 4'(1 << i));
      b_done();
    end
    for (int i = 0; i < 4; i++) begin
      rd(4'(4 * i), 32'(i + 1));
      r_done();
    end
    check("regs_seq", {reg0[7:0], reg1[7:0], reg2[7:0], reg3[7:0]}, 32'h01020304);
    // W first, AW three cycles later
    awaddr = 4'h4; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("wfirst_wait", {bvalid, wready, awready}, 3'b001);
      tick();
    end
    check("wfirst_reg_hold", reg1, 32'h2);
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("wfirst_b", {bvalid, pulse}, 5'b10010);
    check("wfirst_reg", reg1, 32'hDEADBEEF);
    b_done();
    // AW first, W five cycles later
    awaddr = 4'h4; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("awfirst_wait", {bvalid, awready, wready}, 3'b001);
      tick();
    end
    wdata = 32'h12345678; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("awfirst_b", {bvalid, pulse}, 5'b10010);
    check("awfirst_reg", reg1, 32'h12345678);
    b_done();
    // byte strobes
    wr(4'h8, 32'h11223344, 4'hF, 4'b0100);
    b_done();
    wr(4'h8, 32'hAABBCCDD, 4'b0101, 4'b0100);
    check("strb_0101", reg2, 32'h11BB33DD);
    b_done();
    wr(4'hA, 32'hFFFFFFFF, 4'b0000, 4'b0100);
    check("strb_0000", reg2, 32'h11BB33DD);
    b_done();
    // B backpressure
    wr(4'h0, 32'h00000001, 4'hF, 4'b0001);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_b", {bvalid, awready, wready}, 3'b100);
    end
    b_done();
    // R backpressure
    rd(4'h8, 32'h11BB33DD);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_r_data", rdata, 32'h11BB33DD);
      check("bp_r_hs", {rvalid, arready}, 2'b10);
    end
    r_done();
    // same-cycle read and write of reg3
    awaddr = 4'hC; wdata = 32'h55; wstrb = 4'hF; araddr = 4'hC;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("coll_rdata", rdata, 32'h4);
    check("coll_reg3", reg3, 32'h55);
    check("coll_valid", {bvalid, rvalid, pulse}, 6'b111000);
    r_done();
    // reset with BVALID pending
    aresetn = 1'b0;
    tick();
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_reg3", reg3, 32'h0);
    check("rst_pulse", pulse, 4'h0);
    aresetn = 1'b1;
    tick();
    check("rst_rel", {awready, wready, arready, bvalid, rvalid}, 5'b11100);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/trn_dac3482_axil_regs.md
Name: trn_dac3482_axil_regs

Overview:
AXI4-Lite slave register bank for the DAC3482 IC interface. It is the responder to the AXI VIP master used in the block-design bench. It exposes four 32-bit read/write registers to the DAC control logic and emits a one-cycle write-strobe pulse per register. The bench's write-then-readback sequence (0x1..0x4 at 0x0..0xC) must pass against it unmodified.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register.
REG_RESET_VALUE, 32'h0, reset value of all four registers.

Ports:
S_AXI_ACLK  in  1  the single clock for the block.
S_AXI_ARESETN  in  1  reset, synchronous, active-low.
S_AXI_AWADDR  in  4  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID  in  1  write address valid.
S_AXI_AWREADY  out  1  write address ready.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte enables.
S_AXI_WVALID  in  1  write data valid.
S_AXI_WREADY  out  1  write data ready.
S_AXI_BRESP  out  2  write response; always 2'b00.
S_AXI_BVALID  out  1  write response valid.
S_AXI_BREADY  in  1  write response ready.
S_AXI_ARADDR  in  4  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID  in  1  read address valid.
S_AXI_ARREADY  out  1  read address ready.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response; always 2'b00.
S_AXI_RVALID  out  1  read data valid.
S_AXI_RREADY  in  1  read data ready.
reg0_o..reg3_o  out  32 each  current register contents.
reg_wr_pulse_o  out  4  bit k is high for one cycle when register k is written.

Behaviour:
- Reset: checked only on a rising S_AXI_ACLK edge with S_AXI_ARESETN=0.
  - All READY/VALID outputs go to 0; RDATA=0; BRESP=RRESP=0.
  - reg0..3 = REG_RESET_VALUE; reg_wr_pulse_o=0.
  - AW/W holding flags are cleared.
  - A transaction in flight at reset is dropped; no B or R beat is issued for it.
- Write path:
  - AWREADY = !aw_held && !BVALID. WREADY = !w_held && !BVALID. Both are combinational from registered state.
  - AW and W may arrive in either order or together. Each accepted half is held in aw_held/w_held (address and data/strobe latched).
  - Commit condition: AW available (held or handshaking this cycle) AND W available (held or handshaking this cycle).
  - On the commit edge:
    - Selected register bytes are updated where WSTRB[b]=1; bytes with WSTRB[b]=0 keep their value.
    - BVALID is set, the hold flags are cleared, and reg_wr_pulse_o[ADDR[3:2]] is set.
  - Result: with AW+W in cycle N, reg_o and BVALID change at the edge ending N, and pulse/BVALID are visible in N+1.
  - BVALID holds until BREADY. Only one write is outstanding, so no new AW/W is accepted while BVALID=1.
  - WSTRB=0: BVALID still issues and the pulse still fires; the register is unchanged.
- Read path:
  - ARREADY = !RVALID.
  - On AR handshake: RDATA = reg[ARADDR[3:2]] and RVALID=1 on the next edge. RDATA/RVALID are held stable until RREADY.
  - After RVALID&&RREADY, RVALID clears. The next AR can be accepted in the following cycle, giving a maximum rate of one read per 2 cycles.
- Address decode: ADDR[1:0] is ignored. All four offsets are decoded, so there is no SLVERR.
- Simultaneous read and write to the same register: the read returns the pre-write value. Read and write channels are fully independent.
- No combinational path from any input to any VALID output.

Test Plan:
- Reset: ARESETN low for 20 cycles -> all VALID/READY=0, reg0..3=0 throughout; after release AWREADY=WREADY=ARREADY=1.
- Sequential write/readback: write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read each -> BRESP=0 and RDATA=0x1..0x4 with RRESP=0; reg_wr_pulse_o = 0001,0010,0100,1000 one cycle each.
- Channel ordering at 0x4:
  - W alone (0xDEADBEEF), AW 3 cycles later -> single commit, reg1_o=0xDEADBEEF.
  - AW first, W 5 cycles later -> same result.
  - BVALID never asserts before both handshakes.
- Byte strobes: reg2=0x11223344, write 0xAABBCCDD with WSTRB=0101 -> reg2_o=0x11BB33DD; WSTRB=0000 -> reg2 unchanged, BVALID and pulse still issued.
- Backpressure: BREADY low 10 cycles -> AWREADY/WREADY stay 0, BVALID stable. RREADY low 10 cycles -> RDATA stable, ARREADY=0.
- Collision and reset: same-cycle read and write of 0xC (old 0x4, new 0x55) -> RDATA=0x4, reg3_o=0x55. Then reset asserted with BVALID pending -> BVALID=0 next edge, reg3_o=0.
